ad_sampler: RTL and testbench
=============================

AD_SAMPLER -- requirements
Module: ad_sampler

Interface
REQ-001 Parameter CLK_DIV, default 4: ADC sample period in clk cycles; legal range 2..256.
REQ-002 Parameter AVG_LOG2, default 2: each output word is the block average of 2^AVG_LOG2 samples; legal range 0..4.
REQ-003 Parameter WARMUP, default 3: number of samples discarded after enable rises (ADC pipeline latency).
REQ-004 Parameter FIFO_DEPTH, default 8: output buffer depth; power of 2.
REQ-005 clk  in  1  system clock; the only clock.
REQ-006 rst  in  1  reset; asynchronous, active-high.
REQ-007 enable  in  1  sampling run request; level-sensitive.
REQ-008 adc_din  in  8  raw ADC parallel data, unsigned, synchronous to clk.
REQ-009 adc_clk  out  1  ADC conversion clock, registered.
REQ-010 addata  out  8  averaged sample, unsigned; feeds the downstream Re stage.
REQ-011 addata_valid  out  1  addata holds a valid word.
REQ-012 addata_ready  in  1  downstream accepts the word.
REQ-013 overflow  out  1  sticky; a result was dropped because the FIFO was full.
REQ-014 clr_ovf  in  1  synchronous clear of overflow.

Function
REQ-015 The state machine SHALL have exactly three states: IDLE, WARM and RUN.
REQ-016 IDLE->WARM SHALL occur on the first clk edge with enable=1; WARM->RUN after WARMUP sample strobes; WARM or RUN->IDLE on the first edge with enable=0.
REQ-017 With WARMUP=0, WARM SHALL last one clk cycle with no sample discarded.
REQ-018 Divider counter div_cnt SHALL run 0..CLK_DIV-1 and wrap in WARM/RUN; it SHALL be held at 0 in IDLE.
REQ-019 adc_clk SHALL be 1 when div_cnt < CLK_DIV/2 (integer division) and 0 otherwise; it SHALL be 0 in IDLE.
REQ-020 A sample strobe SHALL occur in the cycle where div_cnt==CLK_DIV-1; adc_din SHALL be registered on that edge.
REQ-021 In WARM, strobed samples SHALL be counted and discarded; in RUN they SHALL be added to an accumulator of width 8+AVG_LOG2 (no overflow possible).
REQ-022 After 2^AVG_LOG2 RUN samples, result = accumulator >> AVG_LOG2 (truncation) SHALL be pushed into the FIFO one cycle after the last strobe; the accumulator and sample count SHALL restart at 0 for the next block.
REQ-023 Leaving RUN with a partial block SHALL discard the partial accumulator; FIFO contents SHALL be kept and drained normally.
REQ-024 The FIFO SHALL be first-word-fall-through: addata_valid = not empty, addata = head word.
REQ-025 A pop SHALL occur on a clk edge with addata_valid=1 and addata_ready=1; addata_ready while empty SHALL have no effect.
REQ-026 A word pushed into an empty FIFO SHALL appear with addata_valid=1 in the cycle after the push.
REQ-027 A push SHALL be accepted when the FIFO is not full, or when it is full and a pop occurs on the same edge.
REQ-028 A push to a full FIFO with no pop SHALL be dropped and SHALL set overflow=1; the FIFO contents SHALL be unchanged.
REQ-029 clr_ovf=1 SHALL clear overflow on the next edge; if a drop occurs on the same edge, overflow SHALL be 1.
REQ-030 While addata_valid=1 and addata_ready=0, addata SHALL be held stable.
REQ-031 FIFO read and write pointers SHALL each be log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH.

Reset
REQ-032 While rst=1, the block SHALL be in IDLE with div_cnt, accumulator, sample counters and FIFO pointers at 0.
REQ-033 While rst=1, adc_clk, addata_valid and overflow SHALL be 0, and addata SHALL be 0x00.
REQ-034 Reset asserted mid-operation SHALL take effect immediately (asynchronously), discarding all buffered data.
REQ-035 After rst is released, leaving IDLE SHALL require enable=1 at a clk edge.

Verification
REQ-036 Basic averaging. Defaults; adc_din constant 0x40; enable=1; ready=1 -> 3 samples discarded, then one word 0x40 every 16 clk; adc_clk period 4, high 2.
REQ-037 Truncation. AVG_LOG2=2; RUN samples 0x01,0x02,0x02,0x02 -> sum 7, addata=0x01; samples 0xFF x4 -> addata=0xFF.
REQ-038 Back-pressure and overflow. ready=0 -> 8 words buffered, 9th dropped, overflow=1; addata stays at word 1; ready=1 -> words 1..8 delivered in order.
REQ-039 Full plus simultaneous pop. FIFO full; push and pop on the same edge -> push accepted, overflow stays 0, count remains 8.
REQ-040 Enable drop mid-block. enable=0 after 2 of 4 RUN samples -> no word pushed, adc_clk=0 next cycle; re-enable -> 3 warmup samples discarded again before the next word.
REQ-041 Async reset. rst pulse mid-stream with 5 words buffered and overflow=1 -> valid=0, overflow=0, adc_clk=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/ad_sampler.sv
// ad_sampler: ADC conversion-clock generator with warm-up discard, power-of-two
// block averaging and a first-word-fall-through output buffer with sticky overflow.
module ad_sampler #(
  parameter int CLK_DIV    = 4,
  parameter int AVG_LOG2   = 2,
  parameter int WARMUP     = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] adc_din,
  output logic       adc_clk,
  output logic [7:0] addata,
  output logic       addata_valid,
  input  logic       addata_ready,
  output logic       overflow,
  input  logic       clr_ovf
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WRM_W = $clog2(WARMUP + 1) + 1;
  localparam int SMP_W = AVG_LOG2 + 1;
  localparam int ACC_W = 8 + AVG_LOG2;
  localparam int ADR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PTR_W = ADR_W + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [WRM_W-1:0] WRM_LAST = WRM_W'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WARM,
    S_RUN
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [DIV_W-1:0]   r_div_cnt;
  logic [DIV_W-1:0]   w_div_next;
  logic               w_adc_clk_next;
  logic               r_adc_clk;
  logic               w_strobe;
  logic               w_warm_smp;
  logic               w_run_smp;
  logic [WRM_W-1:0]   r_warm_cnt;

  logic [ACC_W-1:0]   r_acc_p0;
  logic [SMP_W-1:0]   r_smp_cnt_p0;
  logic [ACC_W-1:0]   w_acc_sum_p0;
  logic               w_blk_done_p0;
  logic [7:0]         r_data_p1;
  logic               r_vld_p1;

  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic               r_overflow;

  // Truncating divide by the block size: drop the AVG_LOG2 fraction bits.
  function automatic logic [7:0] f_trunc_avg(input logic [ACC_W-1:0] sum);
    return sum[ACC_W-1:AVG_LOG2];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_div_cnt  <= '0;
      r_adc_clk  <= 1'b0;
      r_warm_cnt <= '0;
    end else begin
      r_state   <= w_next_state;
      r_div_cnt <= w_div_next;
      r_adc_clk <= w_adc_clk_next;
      if (w_next_state != S_WARM) begin
        r_warm_cnt <= '0;
      end else if (w_warm_smp) begin
        r_warm_cnt <= r_warm_cnt + WRM_W'(1);
      end
    end
  end

  // A strobe on the edge that also drops enable is not taken: the run has ended.
  always_comb begin
    w_next_state   = r_state;
    w_strobe       = (r_state != S_IDLE) && (r_div_cnt == DIV_LAST);
    w_warm_smp     = 1'b0;
    w_run_smp      = 1'b0;
    w_div_next     = '0;
    w_adc_clk_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) w_next_state = S_WARM;
      end
      S_WARM: begin
        w_warm_smp = w_strobe && enable;
        if (!enable) begin
          w_next_state = S_IDLE;
        end else if (WARMUP == 0) begin
          w_next_state = S_RUN;
        end else if (w_warm_smp && (r_warm_cnt == WRM_LAST)) begin
          w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        w_run_smp = w_strobe && enable;
        if (!enable) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
    if ((r_state != S_IDLE) && (w_next_state != S_IDLE) && (r_div_cnt != DIV_LAST)) begin
      w_div_next = r_div_cnt + DIV_W'(1);
    end
    w_adc_clk_next = (w_next_state != S_IDLE) && (w_div_next < DIV_HALF);
  end

  assign adc_clk = r_adc_clk;

  // Stage p0: accumulate strobed RUN samples.
  assign w_acc_sum_p0  = r_acc_p0 + ACC_W'(adc_din);
  assign w_blk_done_p0 = w_run_smp && (r_smp_cnt_p0 == SMP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_p0     <= '0;
      r_smp_cnt_p0 <= '0;
      r_vld_p1     <= 1'b0;
    end else begin
      r_vld_p1 <= 1'b0;
      if (r_state != S_RUN) begin
        r_acc_p0     <= '0;
        r_smp_cnt_p0 <= '0;
      end else if (w_blk_done_p0) begin
        r_acc_p0     <= '0;
        r_smp_cnt_p0 <= '0;
        r_vld_p1     <= 1'b1;
      end else if (w_run_smp) begin
        r_acc_p0     <= w_acc_sum_p0;
        r_smp_cnt_p0 <= r_smp_cnt_p0 + SMP_W'(1);
      end
    end
  end

  // Stage p1: averaged word waits one cycle, then is offered to the buffer.
  always_ff @(posedge clk) begin
    if (w_blk_done_p0) r_data_p1 <= f_trunc_avg(w_acc_sum_p0);
  end

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[ADR_W] != r_rd_ptr[ADR_W]) &&
                   (r_wr_ptr[ADR_W-1:0] == r_rd_ptr[ADR_W-1:0]);
  assign w_pop   = !w_empty && addata_ready;
  assign w_push  = r_vld_p1 && (!w_full || w_pop);
  assign w_drop  = r_vld_p1 && w_full && !w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // When full with a pop, the write lands in the slot being read out this edge.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[ADR_W-1:0]] <= r_data_p1;
  end

  assign addata_valid = !w_empty;
  assign addata       = w_empty ? 8'h00 : r_mem[r_rd_ptr[ADR_W-1:0]];
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_ad_sampler.sv
// Scoreboard bench for ad_sampler: a cycle-count reference model queues the
// expected averaged words; a negedge monitor checks outputs and pops on handshake.
`timescale 1ns/1ps
module tb_ad_sampler;
  localparam int CLK_DIV    = 4;
  localparam int AVG_LOG2   = 2;
  localparam int WARMUP     = 3;
  localparam int FIFO_DEPTH = 8;
  localparam int NAVG       = 1 << AVG_LOG2;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] adc_din;
  logic       adc_clk;
  logic [7:0] addata;
  logic       addata_valid;
  logic       addata_ready;
  logic       overflow;
  logic       clr_ovf;

  ad_sampler #(
    .CLK_DIV(CLK_DIV), .AVG_LOG2(AVG_LOG2), .WARMUP(WARMUP), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .adc_din(adc_din), .adc_clk(adc_clk),
    .addata(addata), .addata_valid(addata_valid), .addata_ready(addata_ready),
    .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit         m_active = 0;
  int         m_cyc = 0;
  int         m_sum = 0;
  int         m_n = 0;
  bit         m_pend = 0;
  int         m_pend_val = 0;
  int         m_occ = 0;
  bit         m_ovf = 0;
  logic [7:0] exp_q[$];
  int         pop_cnt = 0;
  logic [7:0] last_pop = 8'h00;

  task automatic model_step();
    bit pop;
    bit drop;
    if (rst) begin
      m_active = 0; m_cyc = 0; m_sum = 0; m_n = 0;
      m_pend = 0; m_occ = 0; m_ovf = 0;
      exp_q.delete();
      return;
    end
    pop  = (m_occ > 0) && addata_ready;
    drop = 0;
    if (m_pend) begin
      if (m_occ < FIFO_DEPTH || pop) begin
        exp_q.push_back(8'(m_pend_val));
        m_occ++;
      end else begin
        drop = 1;
      end
    end
    if (pop) m_occ--;
    if (drop) m_ovf = 1;
    else if (clr_ovf) m_ovf = 0;
    m_pend = 0;
    if (!enable) begin
      m_active = 0; m_sum = 0; m_n = 0;
    end else if (!m_active) begin
      m_active = 1; m_cyc = 0;
    end else begin
      if ((m_cyc % CLK_DIV) == CLK_DIV - 1 && (m_cyc / CLK_DIV) >= WARMUP) begin
        m_sum += int'(adc_din);
        m_n++;
        if (m_n == NAVG) begin
          m_pend = 1; m_pend_val = m_sum / NAVG; m_sum = 0; m_n = 0;
        end
      end
      m_cyc++;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    check_eq("valid", addata_valid, m_occ > 0);
    check_eq("overflow", overflow, m_ovf);
    check_eq("adc_clk", adc_clk, m_active && ((m_cyc % CLK_DIV) < CLK_DIV / 2));
    if (rst) check_eq("rst_addata", addata, 8'h00);
    if (addata_valid && exp_q.size() > 0) begin
      check_eq("data", addata, exp_q[0]);
      if (addata_ready) begin
        last_pop = exp_q.pop_front();
        pop_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic put_sample(input logic [7:0] v);
    adc_din = v;
    repeat (CLK_DIV) @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    enable = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int pc;
    rst = 1'b1; enable = 1'b0; adc_din = 8'h00; addata_ready = 1'b1; clr_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_adc_clk", adc_clk, 1'b0);
    check_eq("reset_valid", addata_valid, 1'b0);
    check_eq("reset_overflow", overflow, 1'b0);
    check_eq("reset_addata", addata, 8'h00);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic averaging: constant input, continuous ready
    adc_din = 8'h40; enable = 1'b1; n = 0;
    do begin @(posedge clk); #1; n++; end while (!addata_valid && n < 200);
    check_eq("first_word_latency", n, 30);
    check_eq("first_word_value", addata, 8'h40);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!addata_valid && n < 200);
    check_eq("word_spacing", n, 16);
    repeat (40) @(posedge clk);
    #1; enable = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    // Truncation
    start_run();
    put_sample(8'hAA); put_sample(8'h55); put_sample(8'hC3);
    put_sample(8'h01); put_sample(8'h02); put_sample(8'h02); put_sample(8'h02);
    put_sample(8'hFF);
    check_eq("trunc_sum7", last_pop, 8'h01);
    put_sample(8'hFF); put_sample(8'hFF); put_sample(8'hFF);
    put_sample(8'h00);
    check_eq("trunc_allff", last_pop, 8'hFF);
    enable = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // Back-pressure and overflow
    addata_ready = 1'b0;
    start_run();
    for (int i = 0; i < WARMUP; i++) put_sample(8'hE0);
    for (int b = 0; b < FIFO_DEPTH + 1; b++)
      for (int s = 0; s < NAVG; s++) put_sample(8'(8'h10 + b));
    @(posedge clk); #1;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("bp_overflow", overflow, 1'b1);
    check_eq("bp_valid", addata_valid, 1'b1);
    check_eq("bp_head", addata, 8'h10);
    pc = pop_cnt;
    addata_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check_eq("bp_drain_count", pop_cnt - pc, FIFO_DEPTH);
    check_eq("bp_last_word", last_pop, 8'h17);
    check_eq("bp_ovf_sticky", overflow, 1'b1);
    clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    check_eq("clr_ovf", overflow, 1'b0);

    // Full FIFO with push and pop on the same edge
    addata_ready = 1'b0;
    start_run();
    for (int i = 0; i < WARMUP; i++) put_sample(8'hE1);
    for (int b = 0; b < FIFO_DEPTH + 1; b++)
      for (int s = 0; s < NAVG; s++) put_sample(8'(8'h30 + b));
    addata_ready = 1'b1;
    @(posedge clk); #1;
    addata_ready = 1'b0; enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("fullpop_overflow", overflow, 1'b0);
    check_eq("fullpop_head", addata, 8'h31);
    check_eq("fullpop_popped", last_pop, 8'h30);
    pc = pop_cnt;
    addata_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check_eq("fullpop_count", pop_cnt - pc, FIFO_DEPTH);
    check_eq("fullpop_last", last_pop, 8'h38);

    // Enable dropped mid-block, then re-enabled
    start_run();
    for (int i = 0; i < WARMUP; i++) put_sample(8'h77);
    put_sample(8'h50); put_sample(8'h50);
    enable = 1'b0;
    pc = pop_cnt;
    @(posedge clk); #1;
    check_eq("drop_adc_clk", adc_clk, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check_eq("drop_no_word", pop_cnt - pc, 0);
    check_eq("drop_valid", addata_valid, 1'b0);
    start_run();
    for (int i = 0; i < WARMUP; i++) put_sample(8'h99);
    for (int s = 0; s < NAVG; s++) put_sample(8'h33);
    put_sample(8'h00);
    check_eq("reenable_word", last_pop, 8'h33);
    check_eq("reenable_count", pop_cnt - pc, 1);
    enable = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Asynchronous reset with buffered data and overflow set
    addata_ready = 1'b0;
    start_run();
    for (int i = 0; i < WARMUP; i++) put_sample(8'hE2);
    for (int b = 0; b < FIFO_DEPTH + 1; b++)
      for (int s = 0; s < NAVG; s++) put_sample(8'(8'h60 + b));
    @(posedge clk); #1;
    enable = 1'b0; addata_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    addata_ready = 1'b0;
    check_eq("prerst_overflow", overflow, 1'b1);
    check_eq("prerst_valid", addata_valid, 1'b1);
    check_eq("prerst_head", addata, 8'h63);
    start_run();
    check_eq("prerst_adc_clk", adc_clk, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_valid", addata_valid, 1'b0);
    check_eq("async_rst_overflow", overflow, 1'b0);
    check_eq("async_rst_adc_clk", adc_clk, 1'b0);
    check_eq("async_rst_addata", addata, 8'h00);
    enable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("post_rst_idle_adc_clk", adc_clk, 1'b0);
    check_eq("post_rst_valid", addata_valid, 1'b0);
    addata_ready = 1'b1;
    pc = pop_cnt;
    start_run();
    for (int i = 0; i < WARMUP; i++) put_sample(8'hE3);
    for (int s = 0; s < NAVG; s++) put_sample(8'h12);
    put_sample(8'h00);
    check_eq("post_rst_word", last_pop, 8'h12);
    check_eq("post_rst_count", pop_cnt - pc, 1);
    enable = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
